// File: rtl/axi_spy_pkg.sv
// Shared definitions for the AXI spy tracer: channel codes and channel count.
// The entry struct's widths follow the top-level parameters, so each tracer instance declares it locally.
package axi_spy_pkg;

   typedef enum logic [1:0] {
      CH_AR = 2'd0,
      CH_AW = 2'd1,
      CH_W  = 2'd2,
      CH_R  = 2'd3
   } spy_ch_e;

   localparam int NUM_CH = 4;

   function automatic int max_width(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spy_trace_fifo.sv
// Circular trace buffer for one snooped channel.
// When full, a push either overwrites the oldest entry or is dropped; both cases set a sticky overflow flag.
module spy_trace_fifo #(
   parameter int WIDTH     = 48,
   parameter int DEPTH     = 16,
   parameter int WRAP_MODE = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             wr_en;
   logic             pop_ok;
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign ovf      = ovf_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign pop_ok   = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      wr_en    = 1'b0;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
         if (push) begin
            // A same-cycle pop frees a slot, so a full buffer still accepts the push.
            if (!full || pop_ok) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (!pop_ok) count_d = count_q + 1'b1;
            end else begin
               ovf_d = 1'b1;
               if (WRAP_MODE != 0) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end else if (pop_ok) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/axi_spy_tracer.sv
// Passive AXI AR/AW/W/R handshake tracer with per-channel timestamped trace buffers
// and a shared pop-style readout port.
module axi_spy_tracer
   import axi_spy_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int TS_WIDTH   = 16,
   parameter int WRAP_MODE  = 1,
   localparam int PW        = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
   localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic                  AWVALID,
   input  logic                  AWREADY,
   input  logic [ADDR_WIDTH-1:0] AW_ADDR,
   input  logic                  WVALID,
   input  logic                  WREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic                  RVALID,
   input  logic                  RREADY,
   input  logic [DATA_WIDTH-1:0] RDATA,
   input  logic                  spy_en,
   input  logic                  clear,
   input  logic                  rd_req,
   input  logic [1:0]            rd_ch,
   output logic                  rd_valid,
   output logic [PW-1:0]         rd_data,
   output logic [TS_WIDTH-1:0]   rd_ts,
   output logic [3:0]            spy_full,
   output logic [3:0]            spy_empty,
   output logic [3:0]            spy_ovf,
   output logic [4*CW-1:0]       spy_count
);

   typedef struct packed {
      logic [PW-1:0]       payload;
      logic [TS_WIDTH-1:0] ts;
   } entry_t;

   localparam int EW = $bits(entry_t);

   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [TS_WIDTH-1:0] cap_ts;
   logic [NUM_CH-1:0]   hs, pop, full, empty, ovf;
   logic [PW-1:0]       payload   [NUM_CH];
   logic [EW-1:0]       fifo_dout [NUM_CH];
   logic [CW-1:0]       count     [NUM_CH];
   entry_t              head;

   logic                rd_valid_q, rd_valid_d;
   logic [PW-1:0]       rd_data_q, rd_data_d;
   logic [TS_WIDTH-1:0] rd_ts_q, rd_ts_d;

   assign hs = {NUM_CH{spy_en}} &
               {RVALID & RREADY, WVALID & WREADY, AWVALID & AWREADY, ARVALID & ARREADY};

   assign payload[CH_AR] = PW'(ARADDR);
   assign payload[CH_AW] = PW'(AW_ADDR);
   assign payload[CH_W]  = PW'(WDATA);
   assign payload[CH_R]  = PW'(RDATA);

   // An entry is stamped with the counter value it holds once the capture edge has passed.
   assign cap_ts = ts_q + 1'b1;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign pop[c] = rd_req && (rd_ch == 2'(c));

      spy_trace_fifo #(
         .WIDTH     (EW),
         .DEPTH     (FIFO_DEPTH),
         .WRAP_MODE (WRAP_MODE)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .clear     (clear),
         .push      (hs[c]),
         .push_data ({payload[c], cap_ts}),
         .pop       (pop[c]),
         .pop_data  (fifo_dout[c]),
         .full      (full[c]),
         .empty     (empty[c]),
         .count     (count[c]),
         .ovf       (ovf[c])
      );

      assign spy_count[c*CW +: CW] = count[c];
   end

   always_comb begin
      head       = entry_t'(fifo_dout[rd_ch]);
      ts_d       = cap_ts;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rd_ts_d    = rd_ts_q;
      if (clear) begin
         ts_d      = '0;
         rd_data_d = '0;
         rd_ts_d   = '0;
      end else if (rd_req && !empty[rd_ch]) begin
         rd_valid_d = 1'b1;
         rd_data_d  = head.payload;
         rd_ts_d    = head.ts;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ts_q       <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_ts_q    <= '0;
      end else begin
         ts_q       <= ts_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_ts_q    <= rd_ts_d;
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_ts     = rd_ts_q;
   assign spy_full  = full;
   assign spy_empty = empty;
   assign spy_ovf   = ovf;

endmodule

// File: tb/tb_axi_spy_tracer.sv
// Bench for axi_spy_tracer: an overwrite-mode and a drop-mode instance share one stimulus stream
// and are compared every cycle against a queue-based model, plus directed literal scenarios.
module tb_axi_spy_tracer;

   localparam int DEPTH = 16;
   localparam int CW    = 5;
   localparam int EW    = 48;

   logic        clk = 1'b0;
   logic        reset, clear, spy_en, rd_req;
   logic [1:0]  rd_ch;
   logic        ARVALID, ARREADY, AWVALID, AWREADY, WVALID, WREADY, RVALID, RREADY;
   logic [31:0] ARADDR, AW_ADDR, WDATA, RDATA;

   logic        rd_valid_o [2];
   logic [31:0] rd_data_o  [2];
   logic [15:0] rd_ts_o    [2];
   logic [3:0]  full_o     [2];
   logic [3:0]  empty_o    [2];
   logic [3:0]  ovf_o      [2];
   logic [19:0] count_o    [2];

   // model state: index 0 = overwrite-mode instance, 1 = drop-mode instance
   logic [EW-1:0] mq [2][4][$];
   logic [3:0]    m_ovf   [2];
   logic          e_valid [2];
   logic [31:0]   e_data  [2];
   logic [15:0]   e_ts    [2];
   logic [15:0]   m_ts;
   bit            chk_en = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axi_spy_tracer #(
         .ADDR_WIDTH (32), .DATA_WIDTH (32), .FIFO_DEPTH (DEPTH),
         .TS_WIDTH (16), .WRAP_MODE ((g == 0) ? 1 : 0)
      ) u_dut (
         .clk (clk), .reset (reset),
         .ARVALID (ARVALID), .ARREADY (ARREADY), .ARADDR (ARADDR),
         .AWVALID (AWVALID), .AWREADY (AWREADY), .AW_ADDR (AW_ADDR),
         .WVALID (WVALID), .WREADY (WREADY), .WDATA (WDATA),
         .RVALID (RVALID), .RREADY (RREADY), .RDATA (RDATA),
         .spy_en (spy_en), .clear (clear), .rd_req (rd_req), .rd_ch (rd_ch),
         .rd_valid (rd_valid_o[g]), .rd_data (rd_data_o[g]), .rd_ts (rd_ts_o[g]),
         .spy_full (full_o[g]), .spy_empty (empty_o[g]), .spy_ovf (ovf_o[g]),
         .spy_count (count_o[g])
      );
   end

   task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, d, $time, act, exp);
      end
   endtask

   function automatic logic [4:0] cnt_of(input int d, input int c);
      return count_o[d][c*CW +: CW];
   endfunction

   // Reference model: each buffer is a queue; a pop takes the front before the cycle's pushes land.
   always @(posedge clk) begin
      logic [3:0]    hs;
      logic [31:0]   pl [4];
      logic [EW-1:0] e;
      hs = {RVALID & RREADY, WVALID & WREADY, AWVALID & AWREADY, ARVALID & ARREADY} & {4{spy_en}};
      pl[0] = ARADDR; pl[1] = AW_ADDR; pl[2] = WDATA; pl[3] = RDATA;
      if (!reset || clear) begin
         if (!reset) chk_en = 1'b1;
         m_ts = '0;
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) mq[d][c].delete();
            m_ovf[d] = '0; e_valid[d] = 1'b0; e_data[d] = '0; e_ts[d] = '0;
         end
      end else begin
         m_ts = m_ts + 16'd1;
         for (int d = 0; d < 2; d++) begin
            e_valid[d] = 1'b0;
            if (rd_req && mq[d][rd_ch].size() > 0) begin
               e = mq[d][rd_ch].pop_front();
               e_valid[d] = 1'b1;
               e_data[d]  = e[47:16];
               e_ts[d]    = e[15:0];
            end
            for (int c = 0; c < 4; c++) begin
               if (hs[c]) begin
                  if (mq[d][c].size() < DEPTH) begin
                     mq[d][c].push_back({pl[c], m_ts});
                  end else begin
                     m_ovf[d][c] = 1'b1;
                     if (d == 0) begin
                        void'(mq[d][c].pop_front());
                        mq[d][c].push_back({pl[c], m_ts});
                     end
                  end
               end
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [3:0]  ex_empty, ex_full;
      logic [19:0] ex_cnt;
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
               ex_empty[c] = (mq[d][c].size() == 0);
               ex_full[c]  = (mq[d][c].size() == DEPTH);
               ex_cnt[c*CW +: CW] = 5'(mq[d][c].size());
            end
            check("rd_valid", d, 64'(rd_valid_o[d]), 64'(e_valid[d]));
            check("rd_data",  d, 64'(rd_data_o[d]),  64'(e_data[d]));
            check("rd_ts",    d, 64'(rd_ts_o[d]),    64'(e_ts[d]));
            check("spy_empty", d, 64'(empty_o[d]),   64'(ex_empty));
            check("spy_full",  d, 64'(full_o[d]),    64'(ex_full));
            check("spy_ovf",   d, 64'(ovf_o[d]),     64'(m_ovf[d]));
            check("spy_count", d, 64'(count_o[d]),   64'(ex_cnt));
         end
      end
   end

   task automatic idle_axi();
      ARVALID = 0; ARREADY = 0; AWVALID = 0; AWREADY = 0;
      WVALID = 0; WREADY = 0; RVALID = 0; RREADY = 0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; spy_en = 1'b1; rd_req = 1'b0; rd_ch = 2'd0;
      ARADDR = 32'h1; AW_ADDR = 32'h2; WDATA = 32'h3; RDATA = 32'h4;
      ARVALID = 1; ARREADY = 1; AWVALID = 1; AWREADY = 1;
      WVALID = 1; WREADY = 1; RVALID = 1; RREADY = 1;

      // reset held with all four channels handshaking
      repeat (4) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            check("rst_empty", d, 64'(empty_o[d]), 64'hF);
            check("rst_count", d, 64'(count_o[d]), 64'h0);
            check("rst_rd_valid", d, 64'(rd_valid_o[d]), 64'h0);
         end
      end
      idle_axi();
      reset = 1'b1;

      // single AR capture at ts=5, then readout
      repeat (4) @(negedge clk);
      ARVALID = 1; ARREADY = 1; ARADDR = 32'hDEAD_BEEF;
      @(negedge clk);
      idle_axi();
      rd_req = 1; rd_ch = 2'd0;
      @(negedge clk);
      rd_req = 0;
      for (int d = 0; d < 2; d++) begin
         check("ar_rd_valid", d, 64'(rd_valid_o[d]), 64'h1);
         check("ar_rd_data", d, 64'(rd_data_o[d]), 64'hDEAD_BEEF);
         check("ar_rd_ts", d, 64'(rd_ts_o[d]), 64'd5);
         check("ar_empty0", d, 64'(empty_o[d][0]), 64'h1);
      end

      // W stalled by WREADY=0, then two beats
      do_clear();
      WVALID = 1; WREADY = 0; WDATA = 32'h99;
      repeat (3) @(negedge clk);
      WREADY = 1; WDATA = 32'h11;
      @(negedge clk);
      WDATA = 32'h22;
      @(negedge clk);
      idle_axi();
      for (int d = 0; d < 2; d++) check("w_count", d, 64'(cnt_of(d, 2)), 64'd2);
      rd_req = 1; rd_ch = 2'd2;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("w_first_data", d, 64'(rd_data_o[d]), 64'h11);
         check("w_first_ts", d, 64'(rd_ts_o[d]), 64'd4);
      end
      @(negedge clk);
      rd_req = 0;
      for (int d = 0; d < 2; d++) begin
         check("w_second_data", d, 64'(rd_data_o[d]), 64'h22);
         check("w_second_ts", d, 64'(rd_ts_o[d]), 64'd5);
      end

      // 18 R beats into a 16-deep buffer
      do_clear();
      RVALID = 1; RREADY = 1;
      for (int i = 1; i <= 18; i++) begin
         RDATA = 32'(i);
         @(negedge clk);
      end
      idle_axi();
      for (int d = 0; d < 2; d++) begin
         check("r_ovf3", d, 64'(ovf_o[d][3]), 64'h1);
         check("r_count3", d, 64'(cnt_of(d, 3)), 64'd16);
      end
      rd_req = 1; rd_ch = 2'd3;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("r_pop_wrap", 0, 64'(rd_data_o[0]), 64'(i + 3));
         check("r_pop_drop", 1, 64'(rd_data_o[1]), 64'(i + 1));
      end
      rd_req = 0;

      // full AW buffer, then push and pop in the same cycle
      do_clear();
      AWVALID = 1; AWREADY = 1;
      for (int i = 0; i < 16; i++) begin
         AW_ADDR = 32'h100 + 32'(i);
         @(negedge clk);
      end
      AW_ADDR = 32'h1FF; rd_req = 1; rd_ch = 2'd1;
      @(negedge clk);
      idle_axi();
      rd_req = 0;
      for (int d = 0; d < 2; d++) begin
         check("aw_pp_valid", d, 64'(rd_valid_o[d]), 64'h1);
         check("aw_pp_data", d, 64'(rd_data_o[d]), 64'h100);
         check("aw_pp_count", d, 64'(cnt_of(d, 1)), 64'd16);
         check("aw_pp_ovf", d, 64'(ovf_o[d][1]), 64'h0);
      end

      // clear coinciding with handshakes on all channels and a pending pop
      ARVALID = 1; ARREADY = 1; AWVALID = 1; AWREADY = 1;
      WVALID = 1; WREADY = 1; RVALID = 1; RREADY = 1;
      rd_req = 1; rd_ch = 2'd1; clear = 1;
      @(negedge clk);
      idle_axi();
      rd_req = 0; clear = 0;
      for (int d = 0; d < 2; d++) begin
         check("clr_empty", d, 64'(empty_o[d]), 64'hF);
         check("clr_ovf", d, 64'(ovf_o[d]), 64'h0);
         check("clr_rd_valid", d, 64'(rd_valid_o[d]), 64'h0);
         check("clr_count", d, 64'(count_o[d]), 64'h0);
      end
      ARVALID = 1; ARREADY = 1; ARADDR = 32'hABC;
      @(negedge clk);
      idle_axi();
      rd_req = 1; rd_ch = 2'd0;
      @(negedge clk);
      rd_req = 0;
      for (int d = 0; d < 2; d++) begin
         check("clr_ts_restart", d, 64'(rd_ts_o[d]), 64'd1);
         check("clr_next_data", d, 64'(rd_data_o[d]), 64'hABC);
      end

      // randomized traffic; odd segments drain heavily
      for (int i = 0; i < 3000; i++) begin
         bit heavy_rd;
         heavy_rd = ((i / 250) % 2) == 1;
         ARVALID = ($urandom_range(0, 3) != 0); ARREADY = ($urandom_range(0, 3) != 0);
         AWVALID = ($urandom_range(0, 3) != 0); AWREADY = ($urandom_range(0, 3) != 0);
         WVALID  = ($urandom_range(0, 3) != 0); WREADY  = ($urandom_range(0, heavy_rd ? 7 : 3) == 0) ? 1'b0 : ~heavy_rd;
         RVALID  = ($urandom_range(0, 3) != 0); RREADY  = heavy_rd ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
         ARADDR = $urandom; AW_ADDR = $urandom; WDATA = $urandom; RDATA = $urandom;
         spy_en = ($urandom_range(0, 9) != 0);
         rd_req = heavy_rd ? 1'b1 : ($urandom_range(0, 1) == 1);
         rd_ch  = 2'($urandom_range(0, 3));
         clear  = ($urandom_range(0, 149) == 0);
         reset  = ($urandom_range(0, 399) != 0);
         @(negedge clk);
      end
      idle_axi();
      rd_req = 0; clear = 0; reset = 1;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
